frame_rx_parser: RTL
====================

# frame_rx_parser

Sits between `uart_rx` and `sobel_applier`. Strips the 4-byte frame header (width LE16, height LE16) off the UART byte stream and latches the frame dimensions. Forwards exactly width×height pixel bytes with valid/ready backpressure, tagging start-of-frame, end-of-line and end-of-frame. A small FIFO absorbs UART bytes, because `uart_rx` cannot be stalled.

## Interface

Parameters:
- `MAX_WIDTH`, 1024: largest accepted width.
- `MAX_HEIGHT`, 1024: largest accepted height.
- `FIFO_DEPTH`, 16: input FIFO entries; must be a power of two and ≥ 4.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte idle limit; used only with the timeout feature.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `data_out` out 8: pixel byte to `sobel_applier`.
- `valid_out` out 1: `data_out` is valid.
- `ready_in` in 1: downstream accepts the byte; transfer when `valid_out && ready_in`.
- `sof` out 1: qualifies the first pixel of a frame.
- `eol` out 1: qualifies the last pixel of a row.
- `eof` out 1: qualifies the last pixel of the frame.
- `width` out 11: latched frame width.
- `height` out 11: latched frame height.
- `frame_active` out 1: payload phase in progress.
- `hdr_err` out 1: one-cycle pulse when a header is rejected.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation

- All received bytes are written to the FIFO. The FSM consumes from the FIFO head.
- `S_HDR`:
  - Pops one byte per cycle while the FIFO is non-empty, with no downstream involvement.
  - A 2-bit counter stores bytes as `width[7:0]`, `width[15:8]`, `height[7:0]`, `height[15:8]`.
  - After the 4th pop, go to `S_CHECK`.
- `S_CHECK` (one cycle):
  - Accept if 1 ≤ w ≤ `MAX_WIDTH` and 1 ≤ h ≤ `MAX_HEIGHT`. Load `width`/`height`, clear `col`/`row`, go to `S_PAYLOAD`.
  - Otherwise pulse `hdr_err`, leave `width`/`height` unchanged, and return to `S_HDR`. The next 4 bytes are treated as a fresh header.
  - Comparisons use the full 16-bit values. Upper bits are then truncated to 11.
- `S_PAYLOAD`:
  - `valid_out` = FIFO non-empty; `data_out` = FIFO head (combinational). Pop on handshake.
  - `sof` = (`col`==0 && `row`==0); `eol` = (`col`==w−1); `eof` = `eol` && (`row`==h−1). All three are qualified by `valid_out`.
  - On handshake:
    - `col` increments.
    - When `col` wraps at w−1: `col`←0 and `row` increments.
    - On the `eof` handshake: return to `S_HDR` with counters cleared.
- FIFO full and `rx_valid` in the same cycle:
  - If a pop also occurs that cycle, the write succeeds.
  - Otherwise the byte is dropped and `overflow` is set.
  - `overflow` clears only on reset.
- `frame_active` = (state == `S_PAYLOAD`).

## Timing

- Reset values: `valid_out`, `sof`, `eol`, `eof`, `frame_active`, `hdr_err`, `overflow` = 0; `width`, `height` = 0; `data_out` = 0 (FIFO empty head reads 0). State = `S_HDR`; FIFO is emptied.
- FIFO latency: a byte written in cycle N is poppable in N+1.
- Header: with the 4th byte written at cycle N, it is popped at N+1, `S_CHECK` is at N+2, and `frame_active`/`width`/`height` are valid from N+3. The first pixel can present `valid_out` at N+3 at the earliest.
- Payload throughput: one byte per cycle while data is available and `ready_in` is high.
- `data_out`/`valid_out` hold stable until accepted. The head only changes on pop.
- `rst` asserted mid-frame: the next cycle is fully reset. Partial headers and payload are discarded.

## Configuration

- `FRAME_RX_PARSER_TIMEOUT_EN` defined:
  - A counter counts cycles with no `rx_valid` while not in `S_HDR` idle with header count 0.
  - Reaching `TIMEOUT_CYCLES` flushes the FIFO, returns to `S_HDR` with the count cleared, and pulses `hdr_err`. This recovers from truncated frames.
- Undefined: no counter exists, and a truncated frame stalls until more bytes arrive.

## Structure

- `frame_pkg`:
  - `parser_state_t` enum (`S_HDR`, `S_CHECK`, `S_PAYLOAD`).
  - `HDR_BYTES` = 4.
  - `DIM_W` = 11.
- Sub-module `sync_fifo`:
  - Parameters: `WIDTH`=8, `DEPTH`.
  - Signals: wr_en/wr_data/full, rd_en/rd_data/empty.
  - Synchronous reset.
  - First-word fall-through head.

## Test plan

- Header 00 04 03 00, then 3072 bytes 0..255 repeating, `ready_in`=1:
  - `width`=1024, `height`=3.
  - 3072 handshakes with data matching the input.
  - `sof` on byte 0; `eol` on indices 1023/2047/3071; `eof` on 3071; then `frame_active`=0.
- Header 04 00 02 00, 8 bytes, `ready_in` pulsed 1-in-10 cycles:
  - Bytes delivered in order.
  - `eol` at index 3 and 7; `overflow` stays 0.
- Header 00 08 01 00 (w=2048):
  - `hdr_err` pulses once; `width`/`height` stay at prior values.
  - A following valid header 02 00 01 00 + 2 bytes is parsed correctly.
- `ready_in`=0 while 20 payload bytes arrive (`FIFO_DEPTH`=16):
  - `overflow`=1; the first 16 bytes are delivered once `ready_in`=1.
- `rst` pulsed after 100 of 3072 payload bytes, then header 02 00 02 00 + 4 bytes:
  - Outputs are at reset values the cycle after `rst`.
  - The new frame parses cleanly.
- With `FRAME_RX_PARSER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=1000: header 10 00 10 00, then 5 bytes, then idle:
  - `hdr_err` pulses 1000 cycles after the last byte; state returns to `S_HDR`.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the UART frame receive path.
package frame_pkg;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_CHECK   = 2'd1,
    S_PAYLOAD = 2'd2
  } parser_state_t;

  localparam int HDR_BYTES = 4;
  localparam int DIM_W     = 11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; an empty FIFO reads zero.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/frame_rx_parser.sv
// Strips the 4-byte LE16 width/height header from the UART stream and forwards the pixels with sof/eol/eof.
// Optional inter-byte timeout recovery is enabled by defining FRAME_RX_PARSER_TIMEOUT_EN.
module frame_rx_parser
  import frame_pkg::*;
#(
  parameter int MAX_WIDTH      = 1024,
  parameter int MAX_HEIGHT     = 1024,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic [DIM_W-1:0] width,
  output logic [DIM_W-1:0] height,
  output logic             frame_active,
  output logic             hdr_err,
  output logic             overflow
);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("frame_rx_parser: invalid parameter set");
  end

  localparam logic [15:0] MAX_W16  = 16'(MAX_WIDTH);
  localparam logic [15:0] MAX_H16  = 16'(MAX_HEIGHT);
  localparam logic [1:0]  HDR_LAST = 2'(HDR_BYTES - 1);

  parser_state_t    state_q, state_d;
  logic [1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [15:0]      hdr_w_q, hdr_w_d;
  logic [15:0]      hdr_h_q, hdr_h_d;
  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] height_q, height_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic             overflow_q, overflow_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_rst;
  logic [7:0] head;
  logic       pop;
  logic       hdr_ok;
  logic       is_eol;
  logic       is_eof;
  logic       hdr_err_c;
  logic       tmo;

  assign fifo_rst = rst | tmo;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (fifo_rst),
    .wr_en  (rx_valid),
    .wr_data(rx_data),
    .full   (fifo_full),
    .rd_en  (pop),
    .rd_data(head),
    .empty  (fifo_empty)
  );

`ifdef FRAME_RX_PARSER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_armed;

  // Idle between frames (no header byte seen yet) is not a truncation.
  assign to_armed = !(state_q == S_HDR && hdr_cnt_q == '0);
  assign tmo      = to_armed && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_valid || !to_armed || tmo) to_cnt_q <= '0;
    else                                     to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Range checks run on the full 16-bit fields before truncation.
  assign hdr_ok = (hdr_w_q != 16'd0) && (hdr_w_q <= MAX_W16) &&
                  (hdr_h_q != 16'd0) && (hdr_h_q <= MAX_H16);
  assign is_eol = (col_q == (width_q - 1'b1));
  assign is_eof = is_eol && (row_q == (height_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    hdr_w_d    = hdr_w_q;
    hdr_h_d    = hdr_h_q;
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    row_d      = row_q;
    pop        = 1'b0;
    hdr_err_c  = 1'b0;
    case (state_q)
      S_HDR: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (hdr_cnt_q)
            2'd0:    hdr_w_d[7:0]  = head;
            2'd1:    hdr_w_d[15:8] = head;
            2'd2:    hdr_h_d[7:0]  = head;
            default: hdr_h_d[15:8] = head;
          endcase
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == HDR_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hdr_ok) begin
          width_d  = hdr_w_q[DIM_W-1:0];
          height_d = hdr_h_q[DIM_W-1:0];
          col_d    = '0;
          row_d    = '0;
          state_d  = S_PAYLOAD;
        end else begin
          hdr_err_c = 1'b1;
          state_d   = S_HDR;
        end
      end
      S_PAYLOAD: begin
        pop = !fifo_empty && ready_in;
        if (pop) begin
          if (is_eol) begin
            col_d = '0;
            if (is_eof) begin
              row_d   = '0;
              state_d = S_HDR;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
    // Timeout abandons whatever was in flight; the FIFO is flushed alongside.
    if (tmo) begin
      state_d   = S_HDR;
      hdr_cnt_d = '0;
      col_d     = '0;
      row_d     = '0;
      pop       = 1'b0;
      hdr_err_c = 1'b1;
    end
  end

  assign overflow_d = overflow_q | (rx_valid && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      hdr_cnt_q  <= '0;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      width_q    <= width_d;
      height_q   <= height_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  // Header byte capture is datapath; a reset discards it through hdr_cnt_q.
  always_ff @(posedge clk) begin
    hdr_w_q <= hdr_w_d;
    hdr_h_q <= hdr_h_d;
  end

  assign frame_active = (state_q == S_PAYLOAD);
  assign valid_out    = frame_active && !fifo_empty;
  assign data_out     = head;
  assign sof          = valid_out && (col_q == '0) && (row_q == '0);
  assign eol          = valid_out && is_eol;
  assign eof          = valid_out && is_eof;
  assign width        = width_q;
  assign height       = height_q;
  assign hdr_err      = hdr_err_c;
  assign overflow     = overflow_q;

endmodule
